// File: rtl/iob2axil.sv
// IOb slave to AXI4-Lite master bridge.
// One outstanding transaction at a time; writes issue AW and W together,
// reads issue AR and return the R data as a one-cycle iob_rvalid_o pulse.
module iob2axil #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  cke_i,

    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  iob_ready_o,

    output logic [ADDR_W-1:0]     axil_awaddr_o,
    output logic [2:0]            axil_awprot_o,
    output logic                  axil_awvalid_o,
    input  logic                  axil_awready_i,

    output logic [DATA_W-1:0]     axil_wdata_o,
    output logic [DATA_W/8-1:0]   axil_wstrb_o,
    output logic                  axil_wvalid_o,
    input  logic                  axil_wready_i,

    input  logic [1:0]            axil_bresp_i,
    input  logic                  axil_bvalid_i,
    output logic                  axil_bready_o,

    output logic [ADDR_W-1:0]     axil_araddr_o,
    output logic [2:0]            axil_arprot_o,
    output logic                  axil_arvalid_o,
    input  logic                  axil_arready_i,

    input  logic [DATA_W-1:0]     axil_rdata_i,
    input  logic [1:0]            axil_rresp_i,
    input  logic                  axil_rvalid_i,
    output logic                  axil_rready_o,

    output logic                  err_o
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA
    } state_t;

    state_t                state;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic                  aw_done;
    logic                  w_done;
    logic                  aw_hs;
    logic                  w_hs;

    // Address, data and strobes come straight from the request registers,
    // so they stay stable for as long as any valid is high.
    assign axil_awaddr_o = addr_q;
    assign axil_araddr_o = addr_q;
    assign axil_wdata_o  = wdata_q;
    assign axil_wstrb_o  = wstrb_q;
    assign axil_awprot_o = 3'b000;
    assign axil_arprot_o = 3'b000;

    assign aw_hs = axil_awvalid_o && axil_awready_i;
    assign w_hs  = axil_wvalid_o && axil_wready_i;

    // Transaction FSM with all handshake outputs registered.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            iob_ready_o    <= 1'b1;
            iob_rvalid_o   <= 1'b0;
            iob_rdata_o    <= '0;
            axil_awvalid_o <= 1'b0;
            axil_wvalid_o  <= 1'b0;
            axil_bready_o  <= 1'b0;
            axil_arvalid_o <= 1'b0;
            axil_rready_o  <= 1'b0;
            err_o          <= 1'b0;
        end else if (cke_i) begin
            iob_rvalid_o <= 1'b0;
            err_o        <= 1'b0;
            case (state)
                IDLE: begin
                    if (iob_avalid_i) begin
                        addr_q      <= iob_addr_i;
                        wdata_q     <= iob_wdata_i;
                        wstrb_q     <= iob_wstrb_i;
                        iob_ready_o <= 1'b0;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        if (iob_wstrb_i != '0) begin
                            state          <= WR_REQ;
                            axil_awvalid_o <= 1'b1;
                            axil_wvalid_o  <= 1'b1;
                        end else begin
                            state          <= RD_REQ;
                            axil_arvalid_o <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently, in either order or together.
                    if (aw_hs) begin
                        axil_awvalid_o <= 1'b0;
                        aw_done        <= 1'b1;
                    end
                    if (w_hs) begin
                        axil_wvalid_o <= 1'b0;
                        w_done        <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state         <= WR_RESP;
                        axil_bready_o <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (axil_bvalid_i) begin
                        state         <= IDLE;
                        axil_bready_o <= 1'b0;
                        iob_ready_o   <= 1'b1;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        err_o         <= (axil_bresp_i != 2'b00);
                    end
                end
                RD_REQ: begin
                    if (axil_arready_i) begin
                        state          <= RD_DATA;
                        axil_arvalid_o <= 1'b0;
                        axil_rready_o  <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (axil_rvalid_i) begin
                        state         <= IDLE;
                        axil_rready_o <= 1'b0;
                        iob_rdata_o   <= axil_rdata_i;
                        iob_rvalid_o  <= 1'b1;
                        iob_ready_o   <= 1'b1;
                        err_o         <= (axil_rresp_i != 2'b00);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob2axil.sv
// Directed testbench for iob2axil. Inputs change and outputs are sampled
// on the falling clock edge; handshakes are counted on the rising edge.
module tb_iob2axil;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            arst_i = 1'b1;
    logic            cke_i = 1'b1;
    logic            iob_avalid_i = 1'b0;
    logic [AW-1:0]   iob_addr_i = '0;
    logic [DW-1:0]   iob_wdata_i = '0;
    logic [DW/8-1:0] iob_wstrb_i = '0;
    logic            iob_rvalid_o;
    logic [DW-1:0]   iob_rdata_o;
    logic            iob_ready_o;
    logic [AW-1:0]   axil_awaddr_o;
    logic [2:0]      axil_awprot_o;
    logic            axil_awvalid_o;
    logic            axil_awready_i = 1'b0;
    logic [DW-1:0]   axil_wdata_o;
    logic [DW/8-1:0] axil_wstrb_o;
    logic            axil_wvalid_o;
    logic            axil_wready_i = 1'b0;
    logic [1:0]      axil_bresp_i = '0;
    logic            axil_bvalid_i = 1'b0;
    logic            axil_bready_o;
    logic [AW-1:0]   axil_araddr_o;
    logic [2:0]      axil_arprot_o;
    logic            axil_arvalid_o;
    logic            axil_arready_i = 1'b0;
    logic [DW-1:0]   axil_rdata_i = '0;
    logic [1:0]      axil_rresp_i = '0;
    logic            axil_rvalid_i = 1'b0;
    logic            axil_rready_o;
    logic            err_o;

    int total = 0;
    int bad = 0;
    int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, rv_n = 0, err_n = 0;

    always #5 clk_i = ~clk_i;

    iob2axil #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
        .iob_avalid_i(iob_avalid_i), .iob_addr_i(iob_addr_i),
        .iob_wdata_i(iob_wdata_i), .iob_wstrb_i(iob_wstrb_i),
        .iob_rvalid_o(iob_rvalid_o), .iob_rdata_o(iob_rdata_o),
        .iob_ready_o(iob_ready_o),
        .axil_awaddr_o(axil_awaddr_o), .axil_awprot_o(axil_awprot_o),
        .axil_awvalid_o(axil_awvalid_o), .axil_awready_i(axil_awready_i),
        .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o),
        .axil_wvalid_o(axil_wvalid_o), .axil_wready_i(axil_wready_i),
        .axil_bresp_i(axil_bresp_i), .axil_bvalid_i(axil_bvalid_i),
        .axil_bready_o(axil_bready_o),
        .axil_araddr_o(axil_araddr_o), .axil_arprot_o(axil_arprot_o),
        .axil_arvalid_o(axil_arvalid_o), .axil_arready_i(axil_arready_i),
        .axil_rdata_i(axil_rdata_i), .axil_rresp_i(axil_rresp_i),
        .axil_rvalid_i(axil_rvalid_i), .axil_rready_o(axil_rready_o),
        .err_o(err_o)
    );

    // Handshake and pulse counters, only on enabled, out-of-reset edges.
    always @(posedge clk_i) begin
        if (cke_i && arst_i) begin
            if (axil_awvalid_o && axil_awready_i) aw_n++;
            if (axil_wvalid_o && axil_wready_i)   w_n++;
            if (axil_bready_o && axil_bvalid_i)   b_n++;
            if (axil_arvalid_o && axil_arready_i) ar_n++;
            if (axil_rready_o && axil_rvalid_i)   r_n++;
            if (iob_rvalid_o)                     rv_n++;
            if (err_o)                            err_n++;
        end
    end

    task automatic nxt();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        iob_avalid_i = 1'b0; iob_wstrb_i = '0;
        axil_awready_i = 1'b0; axil_wready_i = 1'b0; axil_bvalid_i = 1'b0;
        axil_bresp_i = '0; axil_arready_i = 1'b0; axil_rvalid_i = 1'b0;
        axil_rresp_i = '0;
    endtask

    task automatic test_reset();
        #1 arst_i = 1'b0;
        repeat (2) nxt();
        total++;
        if ({iob_ready_o, axil_awvalid_o, axil_wvalid_o, axil_arvalid_o, axil_bready_o,
             axil_rready_o, iob_rvalid_o, err_o} !== 8'b1000_0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=10000000", {iob_ready_o, axil_awvalid_o,
                     axil_wvalid_o, axil_arvalid_o, axil_bready_o, axil_rready_o,
                     iob_rvalid_o, err_o});
        end
        total++;
        if ({iob_rdata_o, axil_awaddr_o, axil_wdata_o, axil_wstrb_o} !== '0) begin
            bad++;
            $display("FAIL reset_data rdata=%h awaddr=%h wdata=%h wstrb=%h exp=0",
                     iob_rdata_o, axil_awaddr_o, axil_wdata_o, axil_wstrb_o);
        end
        total++;
        if ({axil_awprot_o, axil_arprot_o} !== 6'b0) begin
            bad++;
            $display("FAIL prot got=%b exp=000000", {axil_awprot_o, axil_arprot_o});
        end
        arst_i = 1'b1;
        nxt();
        total++;
        if (iob_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b exp=1", iob_ready_o);
        end
    endtask

    task automatic test_write_zero_wait();
        int a0, w0, b0, e0;
        a0 = aw_n; w0 = w_n; b0 = b_n; e0 = err_n;
        iob_avalid_i = 1'b1; iob_addr_i = 32'h1000_0004;
        iob_wdata_i = 32'hDEAD_BEEF; iob_wstrb_i = 4'hF;
        axil_awready_i = 1'b1; axil_wready_i = 1'b1; axil_bvalid_i = 1'b1;
        nxt();
        iob_avalid_i = 1'b0;
        total++;
        if ({axil_awvalid_o, axil_wvalid_o, iob_ready_o, axil_bready_o} !== 4'b1100) begin
            bad++;
            $display("FAIL wr_t1_ctrl got=%b exp=1100",
                     {axil_awvalid_o, axil_wvalid_o, iob_ready_o, axil_bready_o});
        end
        total++;
        if ({axil_awaddr_o, axil_wdata_o, axil_wstrb_o} !== {32'h1000_0004, 32'hDEAD_BEEF, 4'hF}) begin
            bad++;
            $display("FAIL wr_fields got=%h/%h/%h exp=10000004/deadbeef/f",
                     axil_awaddr_o, axil_wdata_o, axil_wstrb_o);
        end
        nxt();
        total++;
        if ({axil_awvalid_o, axil_wvalid_o, axil_bready_o, iob_ready_o} !== 4'b0010) begin
            bad++;
            $display("FAIL wr_t2_ctrl got=%b exp=0010",
                     {axil_awvalid_o, axil_wvalid_o, axil_bready_o, iob_ready_o});
        end
        nxt();
        total++;
        if ({iob_ready_o, axil_bready_o, err_o, iob_rvalid_o} !== 4'b1000) begin
            bad++;
            $display("FAIL wr_t3_ctrl got=%b exp=1000",
                     {iob_ready_o, axil_bready_o, err_o, iob_rvalid_o});
        end
        clear_inputs();
        nxt();
        total++;
        if ({aw_n - a0, w_n - w0, b_n - b0, err_n - e0} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin
            bad++;
            $display("FAIL wr_counts aw=%0d w=%0d b=%0d err=%0d exp=1 1 1 0",
                     aw_n - a0, w_n - w0, b_n - b0, err_n - e0);
        end
    endtask

    task automatic test_read_wait();
        int v0;
        v0 = rv_n;
        iob_avalid_i = 1'b1; iob_addr_i = 32'h2000_0000; iob_wstrb_i = 4'h0;
        axil_arready_i = 1'b1;
        nxt();
        iob_avalid_i = 1'b0;
        total++;
        if ({axil_arvalid_o, iob_ready_o, axil_rready_o, axil_awvalid_o} !== 4'b1000 ||
            axil_araddr_o !== 32'h2000_0000) begin
            bad++;
            $display("FAIL rd_t1 got=%b araddr=%h exp=1000 20000000",
                     {axil_arvalid_o, iob_ready_o, axil_rready_o, axil_awvalid_o}, axil_araddr_o);
        end
        nxt();
        axil_arready_i = 1'b0;
        total++;
        if ({axil_arvalid_o, axil_rready_o} !== 2'b01) begin
            bad++;
            $display("FAIL rd_t2 got=%b exp=01", {axil_arvalid_o, axil_rready_o});
        end
        for (int i = 0; i < 2; i++) begin
            nxt();
            total++;
            if ({axil_rready_o, iob_rvalid_o, iob_ready_o} !== 3'b100) begin
                bad++;
                $display("FAIL rd_wait%0d got=%b exp=100", i, {axil_rready_o, iob_rvalid_o, iob_ready_o});
            end
        end
        nxt();
        axil_rvalid_i = 1'b1; axil_rdata_i = 32'h1234_5678; axil_rresp_i = 2'b00;
        nxt();
        axil_rvalid_i = 1'b0; axil_rdata_i = 32'hFFFF_0000;
        total++;
        if ({iob_rvalid_o, iob_ready_o, axil_rready_o, err_o} !== 4'b1100 ||
            iob_rdata_o !== 32'h1234_5678) begin
            bad++;
            $display("FAIL rd_done got=%b rdata=%h exp=1100 12345678",
                     {iob_rvalid_o, iob_ready_o, axil_rready_o, err_o}, iob_rdata_o);
        end
        nxt();
        total++;
        if (iob_rvalid_o !== 1'b0 || iob_rdata_o !== 32'h1234_5678 || rv_n - v0 != 1) begin
            bad++;
            $display("FAIL rd_hold rvalid=%b rdata=%h pulses=%0d exp=0 12345678 1",
                     iob_rvalid_o, iob_rdata_o, rv_n - v0);
        end
    endtask

    task automatic test_write_order(input int w_at, input int aw_at, input string tag);
        int a0, w0, b0, m;
        logic [2:0] exp;
        a0 = aw_n; w0 = w_n; b0 = b_n;
        m = (w_at > aw_at) ? w_at : aw_at;
        iob_avalid_i = 1'b1; iob_addr_i = 32'h3000_0010; iob_wdata_i = 32'h0BAD_F00D;
        iob_wstrb_i = 4'b0011;
        for (int c = 1; c <= m; c++) begin
            nxt();
            iob_avalid_i = 1'b0;
            iob_addr_i = 32'h0; iob_wdata_i = 32'h0;
            exp = {1'(c <= aw_at), 1'(c <= w_at), 1'b0};
            total++;
            if ({axil_awvalid_o, axil_wvalid_o, axil_bready_o} !== exp ||
                {axil_awaddr_o, axil_wdata_o, axil_wstrb_o} !== {32'h3000_0010, 32'h0BAD_F00D, 4'b0011}) begin
                bad++;
                $display("FAIL %s_c%0d got=%b fields=%h/%h/%h exp=%b 30000010/0badf00d/3", tag, c,
                         {axil_awvalid_o, axil_wvalid_o, axil_bready_o},
                         axil_awaddr_o, axil_wdata_o, axil_wstrb_o, exp);
            end
            axil_wready_i  = (c >= w_at);
            axil_awready_i = (c >= aw_at);
        end
        nxt();
        axil_awready_i = 1'b0; axil_wready_i = 1'b0; axil_bvalid_i = 1'b1;
        total++;
        if ({axil_awvalid_o, axil_wvalid_o, axil_bready_o} !== 3'b001) begin
            bad++;
            $display("FAIL %s_resp got=%b exp=001", tag, {axil_awvalid_o, axil_wvalid_o, axil_bready_o});
        end
        nxt();
        axil_bvalid_i = 1'b0;
        total++;
        if ({iob_ready_o, axil_bready_o, iob_rvalid_o} !== 3'b100 ||
            aw_n - a0 != 1 || w_n - w0 != 1 || b_n - b0 != 1) begin
            bad++;
            $display("FAIL %s_end got=%b aw=%0d w=%0d b=%0d exp=100 1 1 1", tag,
                     {iob_ready_o, axil_bready_o, iob_rvalid_o}, aw_n - a0, w_n - w0, b_n - b0);
        end
    endtask

    task automatic test_read_err();
        int e0, v0;
        e0 = err_n; v0 = rv_n;
        iob_avalid_i = 1'b1; iob_addr_i = 32'h0000_0040; iob_wstrb_i = 4'h0;
        axil_arready_i = 1'b1; axil_rvalid_i = 1'b1; axil_rresp_i = 2'b10;
        axil_rdata_i = 32'hCAFE_F00D;
        nxt();
        iob_avalid_i = 1'b0;
        nxt();
        nxt();
        clear_inputs();
        total++;
        if ({iob_rvalid_o, err_o, iob_ready_o} !== 3'b111 || iob_rdata_o !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL rderr_done got=%b rdata=%h exp=111 cafef00d",
                     {iob_rvalid_o, err_o, iob_ready_o}, iob_rdata_o);
        end
        nxt();
        total++;
        if ({iob_rvalid_o, err_o} !== 2'b00 || err_n - e0 != 1 || rv_n - v0 != 1) begin
            bad++;
            $display("FAIL rderr_after got=%b err_pulses=%0d rv_pulses=%0d exp=00 1 1",
                     {iob_rvalid_o, err_o}, err_n - e0, rv_n - v0);
        end
    endtask

    task automatic test_back_to_back();
        int a0, b0;
        a0 = aw_n; b0 = b_n;
        iob_avalid_i = 1'b1; iob_addr_i = 32'h0000_0100; iob_wdata_i = 32'h1; iob_wstrb_i = 4'hF;
        axil_awready_i = 1'b1; axil_wready_i = 1'b1; axil_bvalid_i = 1'b1;
        nxt();
        total++;
        if (iob_ready_o !== 1'b0 || axil_awaddr_o !== 32'h0000_0100) begin
            bad++;
            $display("FAIL b2b_first ready=%b awaddr=%h exp=0 00000100", iob_ready_o, axil_awaddr_o);
        end
        iob_addr_i = 32'h0000_0200; iob_wdata_i = 32'h2;
        nxt();
        nxt();
        total++;
        if (iob_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready got=%b exp=1", iob_ready_o);
        end
        nxt();
        iob_avalid_i = 1'b0;
        total++;
        if ({iob_ready_o, axil_awvalid_o} !== 2'b01 || axil_awaddr_o !== 32'h0000_0200 ||
            axil_wdata_o !== 32'h2) begin
            bad++;
            $display("FAIL b2b_second got=%b awaddr=%h wdata=%h exp=01 00000200 2",
                     {iob_ready_o, axil_awvalid_o}, axil_awaddr_o, axil_wdata_o);
        end
        repeat (3) nxt();
        clear_inputs();
        total++;
        if ({iob_ready_o, axil_awvalid_o} !== 2'b10 || aw_n - a0 != 2 || b_n - b0 != 2) begin
            bad++;
            $display("FAIL b2b_end got=%b aw=%0d b=%0d exp=10 2 2",
                     {iob_ready_o, axil_awvalid_o}, aw_n - a0, b_n - b0);
        end
    endtask

    task automatic test_cke();
        int r0;
        r0 = ar_n;
        iob_avalid_i = 1'b1; iob_addr_i = 32'h0000_0044; iob_wstrb_i = 4'h0;
        nxt();
        iob_avalid_i = 1'b0;
        cke_i = 1'b0; axil_arready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nxt();
            total++;
            if ({axil_arvalid_o, axil_rready_o} !== 2'b10) begin
                bad++;
                $display("FAIL cke_hold%0d got=%b exp=10", i, {axil_arvalid_o, axil_rready_o});
            end
        end
        cke_i = 1'b1;
        nxt();
        axil_arready_i = 1'b0; axil_rvalid_i = 1'b1; axil_rdata_i = 32'hA5A5_5A5A;
        total++;
        if ({axil_arvalid_o, axil_rready_o} !== 2'b01 || ar_n - r0 != 1) begin
            bad++;
            $display("FAIL cke_resume got=%b ar=%0d exp=01 1", {axil_arvalid_o, axil_rready_o}, ar_n - r0);
        end
        nxt();
        cke_i = 1'b0; axil_rvalid_i = 1'b0;
        nxt();
        total++;
        if (iob_rvalid_o !== 1'b1 || iob_rdata_o !== 32'hA5A5_5A5A) begin
            bad++;
            $display("FAIL cke_pulse_frozen rvalid=%b rdata=%h exp=1 a5a55a5a", iob_rvalid_o, iob_rdata_o);
        end
        cke_i = 1'b1;
        nxt();
        total++;
        if ({iob_rvalid_o, iob_ready_o} !== 2'b01) begin
            bad++;
            $display("FAIL cke_pulse_end got=%b exp=01", {iob_rvalid_o, iob_ready_o});
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        int b0;
        b0 = b_n;
        iob_avalid_i = 1'b1; iob_addr_i = 32'h0000_0080; iob_wdata_i = 32'h55; iob_wstrb_i = 4'h1;
        axil_bvalid_i = 1'b1;
        nxt();
        iob_avalid_i = 1'b0;
        total++;
        if ({axil_awvalid_o, axil_wvalid_o} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid_pre got=%b exp=11", {axil_awvalid_o, axil_wvalid_o});
        end
        #2 arst_i = 1'b0;
        #1;
        total++;
        if ({axil_awvalid_o, axil_wvalid_o, iob_ready_o, axil_bready_o} !== 4'b0010) begin
            bad++;
            $display("FAIL rstmid_async got=%b exp=0010",
                     {axil_awvalid_o, axil_wvalid_o, iob_ready_o, axil_bready_o});
        end
        nxt();
        arst_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nxt();
            total++;
            if ({iob_ready_o, axil_bready_o, axil_awvalid_o, axil_wvalid_o, err_o} !== 5'b10000) begin
                bad++;
                $display("FAIL rstmid_after%0d got=%b exp=10000", i,
                         {iob_ready_o, axil_bready_o, axil_awvalid_o, axil_wvalid_o, err_o});
            end
        end
        clear_inputs();
        total++;
        if (b_n - b0 != 0) begin
            bad++;
            $display("FAIL rstmid_no_b got=%0d exp=0", b_n - b0);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_write_order(1, 5, "w_first");
        test_write_order(5, 1, "aw_first");
        test_write_order(3, 3, "same_cycle");
        test_read_err();
        test_back_to_back();
        test_cke();
        test_reset_mid();
        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
